// File: rtl/doframe_seq.sv
// Ping-pong frame buffer and sequencer feeding the doled serializer: START, NUM_LEDS LED words, END.
// Bank swaps are taken only at frame starts so a displayed frame is never torn.
module doframe_seq #(
  parameter int NUM_LEDS  = 47,
  parameter int ADDR_W    = 6,
  parameter int FRAME_GAP = 1000
) (
  input  logic              doframe_clk,
  input  logic              doframe_reset_n,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_blue,
  input  logic [7:0]        wr_green,
  input  logic [7:0]        wr_red,
  input  logic              wr_commit,
  output logic              wr_ready,
  output logic [7:0]        blue_out,
  output logic [7:0]        green_out,
  output logic [7:0]        red_out,
  output logic [1:0]        type_out,
  output logic              led_start,
  input  logic              doled_busy,
  output logic              active_bank,
  output logic              frame_done,
  output logic              frame_swapped
);

  localparam int MW = $clog2(2 * NUM_LEDS);
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [7:0]      LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(FRAME_GAP - 1);
  localparam logic [1:0] T_START = 2'd0;
  localparam logic [1:0] T_LED   = 2'd1;
  localparam logic [1:0] T_END   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_ACK, S_WAIT, S_READ, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        active_bank_q, active_bank_d;
  logic        swap_pending_q, swap_pending_d;
  logic [1:0]  type_q, type_d;
  logic [23:0] colour_q, colour_d;
  logic        led_start_q, led_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_swapped_q, frame_swapped_d;
  logic        go_start;

  // Flat storage: bank 0 occupies [0, NUM_LEDS), bank 1 follows it.
  logic [23:0]   mem [2*NUM_LEDS];
  logic [MW-1:0] wr_idx, rd_idx;
  logic          wr_ok;
  logic [23:0]   rd_dat;

  assign wr_ok  = wr_en && !swap_pending_q && ({1'b0, wr_addr} < ADDR_LIM);
  assign wr_idx = MW'(wr_addr) + (active_bank_q ? '0 : MW'(NUM_LEDS));
  assign rd_idx = MW'(idx_q) + (active_bank_q ? MW'(NUM_LEDS) : '0);
  assign rd_dat = mem[rd_idx];

  always_ff @(posedge doframe_clk) begin
    if (wr_ok) mem[wr_idx] <= {wr_red, wr_green, wr_blue};
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    gap_d           = gap_q;
    active_bank_d   = active_bank_q;
    swap_pending_d  = swap_pending_q | wr_commit;
    type_d          = type_q;
    colour_d        = colour_q;
    led_start_d     = 1'b0;
    frame_done_d    = 1'b0;
    frame_swapped_d = 1'b0;
    go_start        = 1'b0;
    unique case (state_q)
      S_IDLE: go_start = run && !doled_busy;
      S_SEND: state_d = S_ACK;
      S_ACK:  state_d = S_WAIT;
      S_WAIT: begin
        if (!doled_busy) begin
          if (type_q == T_START) begin
            idx_d   = '0;
            state_d = S_READ;
          end else if (type_q == T_LED) begin
            if (idx_q < LAST_IDX) begin
              idx_d   = idx_q + 8'd1;
              state_d = S_READ;
            end else begin
              state_d     = S_SEND;
              led_start_d = 1'b1;
              type_d      = T_END;
              colour_d    = '0;
            end
          end else begin
            frame_done_d = 1'b1;
            gap_d        = '0;
            state_d      = S_GAP;
          end
        end
      end
      // Synchronous read: address presented here, data lands in the output register.
      S_READ: begin
        state_d     = S_SEND;
        led_start_d = 1'b1;
        type_d      = T_LED;
        colour_d    = rd_dat;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (run) go_start = 1'b1;
          else     state_d  = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_start) begin
      state_d     = S_SEND;
      led_start_d = 1'b1;
      type_d      = T_START;
      colour_d    = '0;
      // A commit landing on the swap cycle is queued for the following frame.
      if (swap_pending_q) begin
        active_bank_d   = ~active_bank_q;
        swap_pending_d  = wr_commit;
        frame_swapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge doframe_clk or negedge doframe_reset_n) begin
    if (!doframe_reset_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      gap_q           <= '0;
      active_bank_q   <= 1'b0;
      swap_pending_q  <= 1'b0;
      type_q          <= T_START;
      colour_q        <= '0;
      led_start_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_swapped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      gap_q           <= gap_d;
      active_bank_q   <= active_bank_d;
      swap_pending_q  <= swap_pending_d;
      type_q          <= type_d;
      colour_q        <= colour_d;
      led_start_q     <= led_start_d;
      frame_done_q    <= frame_done_d;
      frame_swapped_q <= frame_swapped_d;
    end
  end

  assign wr_ready      = ~swap_pending_q;
  assign red_out       = colour_q[23:16];
  assign green_out     = colour_q[15:8];
  assign blue_out      = colour_q[7:0];
  assign type_out      = type_q;
  assign led_start     = led_start_q;
  assign active_bank   = active_bank_q;
  assign frame_done    = frame_done_q;
  assign frame_swapped = frame_swapped_q;

endmodule
